// File: rtl/pc_sequencer_pkg.sv
// Constants shared by the fetch-stage PC sequencer: next-PC opcodes, default
// vectors and the legal instruction address window.
package pc_sequencer_pkg;

  localparam int unsigned NPCOp_PC4 = 0;
  localparam int unsigned NPCOp_Br  = 1;
  localparam int unsigned NPCOp_JL  = 2;
  localparam int unsigned NPCOp_JR  = 3;

  localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] DEF_EXC_VEC  = 32'h0000_4180;

  localparam logic [31:0] PC_MIN = 32'h0000_3000;
  localparam logic [31:0] PC_MAX = 32'h0000_6ffc;

  typedef enum logic {
    ST_RUN,
    ST_HOLD
  } seq_state_e;

endpackage

// File: rtl/pc_sequencer_npc_target.sv
// Combinational next-PC target decode from the D-stage operands.
// Zero latency; no flow control, redirect_o=0 means "no redirect requested".
module npc_target
  import pc_sequencer_pkg::*;
#(
  parameter int OP_W = 4
) (
  input  logic [OP_W-1:0] npc_op_i,
  input  logic            branch_i,
  input  logic [31:0]     d_pc_i,
  input  logic [15:0]     imm16_i,
  input  logic [25:0]     imm26_i,
  input  logic [31:0]     rs_i,
  output logic            redirect_o,
  output logic [31:0]     target_o
);

  logic [31:0] br_off;

  assign br_off = {{14{imm16_i[15]}}, imm16_i, 2'b00};

  always_comb begin
    redirect_o = 1'b0;
    target_o   = '0;
    case (npc_op_i)
      OP_W'(NPCOp_Br): begin
        if (branch_i) begin
          redirect_o = 1'b1;
          target_o   = d_pc_i + 32'd4 + br_off;
        end
      end
      OP_W'(NPCOp_JL): begin
        redirect_o = 1'b1;
        target_o   = {d_pc_i[31:28], imm26_i, 2'b00};
      end
      OP_W'(NPCOp_JR): begin
        redirect_o = 1'b1;
        target_o   = rs_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC register with branch/jump/exception redirect; a redirect seen while imem is busy waits in a one-entry pending slot.
// One-edge redirect latency; stall freezes all but exc/eret. PC_ADEL_CHECK_EN enables the fetch address-error flag.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter logic [31:0] EXC_VEC  = DEF_EXC_VEC,
  parameter int          OP_W     = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            fetch_ready,
  input  logic [31:0]     d_pc,
  input  logic [OP_W-1:0] npc_op,
  input  logic [15:0]     imm16,
  input  logic [25:0]     imm26,
  input  logic [31:0]     rs,
  input  logic            branch,
  input  logic            exc_req,
  input  logic            eret_req,
  input  logic [31:0]     epc,
  output logic [31:0]     F_PC,
  output logic            redirect_pending,
  output logic            pc_adel
);

  seq_state_e  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_q, pend_d;
  logic        redirect;
  logic [31:0] target;

  npc_target #(.OP_W(OP_W)) u_npc_target (
    .npc_op_i   (npc_op),
    .branch_i   (branch),
    .d_pc_i     (d_pc),
    .imm16_i    (imm16),
    .imm26_i    (imm26),
    .rs_i       (rs),
    .redirect_o (redirect),
    .target_o   (target)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pend_d  = pend_q;
    if (exc_req) begin
      pc_d    = EXC_VEC;
      pend_d  = '0;
      state_d = ST_RUN;
    end else if (eret_req) begin
      pc_d    = epc;
      pend_d  = '0;
      state_d = ST_RUN;
    end else if (stall) begin
      // D re-presents its redirect once the stall lifts, so nothing is captured here.
    end else if (state_q == ST_HOLD && fetch_ready) begin
      pc_d    = redirect ? target : pend_q;
      pend_d  = '0;
      state_d = ST_RUN;
    end else if (redirect && fetch_ready) begin
      pc_d = target;
    end else if (redirect) begin
      pend_d  = target;
      state_d = ST_HOLD;
    end else if (fetch_ready) begin
      pc_d = pc_q + 32'd4;
    end
  end

  assign F_PC             = pc_q;
  assign redirect_pending = (state_q == ST_HOLD);

`ifdef PC_ADEL_CHECK_EN
  assign pc_adel = (pc_q[1:0] != 2'b00) || (pc_q < PC_MIN) || (pc_q > PC_MAX);
`else
  assign pc_adel = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed and random bench for pc_sequencer against a behavioural next-PC model.
module tb_pc_sequencer;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        fetch_ready;
  logic [31:0] d_pc;
  logic [3:0]  npc_op;
  logic [15:0] imm16;
  logic [25:0] imm26;
  logic [31:0] rs;
  logic        branch;
  logic        exc_req;
  logic        eret_req;
  logic [31:0] epc;
  logic [31:0] F_PC;
  logic        redirect_pending;
  logic        pc_adel;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: the architectural PC and an optional pending target.
  logic [31:0] m_pc;
  bit          m_pend_vld;
  logic [31:0] m_pend;

  pc_sequencer dut (
    .clk              (clk),
    .reset            (reset),
    .stall            (stall),
    .fetch_ready      (fetch_ready),
    .d_pc             (d_pc),
    .npc_op           (npc_op),
    .imm16            (imm16),
    .imm26            (imm26),
    .rs               (rs),
    .branch           (branch),
    .exc_req          (exc_req),
    .eret_req         (eret_req),
    .epc              (epc),
    .F_PC             (F_PC),
    .redirect_pending (redirect_pending),
    .pc_adel          (pc_adel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit exp_adel(input logic [31:0] pc);
`ifdef PC_ADEL_CHECK_EN
    return (pc % 4 != 0) || (pc < 32'h3000) || (pc > 32'h6ffc);
`else
    return 1'b0;
`endif
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".F_PC"}, F_PC, m_pc);
    chk({tag, ".pend"}, {31'd0, redirect_pending}, {31'd0, m_pend_vld});
    chk({tag, ".adel"}, {31'd0, pc_adel}, {31'd0, exp_adel(m_pc)});
  endtask

  function automatic void model_target(output bit rd, output logic [31:0] tgt);
    int signed off;
    rd  = 1'b0;
    tgt = 32'd0;
    off = $signed(imm16) * 4;
    if (npc_op == 4'd1 && branch) begin
      rd = 1'b1; tgt = d_pc + 32'd4 + off;
    end else if (npc_op == 4'd2) begin
      rd = 1'b1; tgt = (d_pc & 32'hf000_0000) + (32'(imm26) * 4);
    end else if (npc_op == 4'd3) begin
      rd = 1'b1; tgt = rs;
    end
  endfunction

  task automatic model_reset();
    m_pc = 32'h3000; m_pend_vld = 1'b0; m_pend = 32'd0;
  endtask

  task automatic cyc(input string tag);
    bit          rd;
    logic [31:0] tgt, n_pc, n_pend;
    bit          n_vld;
    model_target(rd, tgt);
    n_pc = m_pc; n_vld = m_pend_vld; n_pend = m_pend;
    if (exc_req) begin
      n_pc = 32'h4180; n_vld = 0;
    end else if (eret_req) begin
      n_pc = epc; n_vld = 0;
    end else if (stall) begin
      n_pc = m_pc;
    end else if (fetch_ready) begin
      if (rd) n_pc = tgt;
      else if (m_pend_vld) n_pc = m_pend;
      else n_pc = m_pc + 32'd4;
      n_vld = 0;
    end else if (rd) begin
      n_pend = tgt; n_vld = 1;
    end
    @(posedge clk);
    #1;
    m_pc = n_pc; m_pend_vld = n_vld; m_pend = n_pend;
    check_all(tag);
  endtask

  task automatic idle_inputs();
    stall = 0; fetch_ready = 0; d_pc = 32'h3000; npc_op = 4'd0; imm16 = 0;
    imm26 = 0; rs = 0; branch = 0; exc_req = 0; eret_req = 0; epc = 0;
  endtask

  initial begin
    reset = 1'b0;
    idle_inputs();
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Sequential fetch 3000 -> 300c.
    fetch_ready = 1;
    repeat (3) cyc("seq");
    chk("seq_end", F_PC, 32'h300c);

    // Backward branch from 3004.
    npc_op = 4'd1; branch = 1; d_pc = 32'h3004; imm16 = 16'hfffe;
    cyc("br");
    chk("br_tgt", F_PC, 32'h3000);

    // JR while imem busy, then released.
    npc_op = 4'd3; rs = 32'h3400; branch = 0; fetch_ready = 0;
    repeat (2) cyc("jr_busy");
    chk("jr_pend", {31'd0, redirect_pending}, 32'd1);
    npc_op = 4'd0; fetch_ready = 1;
    cyc("jr_rel");
    chk("jr_tgt", F_PC, 32'h3400);

    // Exception while stalled in HOLD, then eret.
    npc_op = 4'd3; rs = 32'h3500; fetch_ready = 0;
    cyc("hold");
    npc_op = 4'd0; stall = 1; exc_req = 1;
    cyc("exc");
    chk("exc_tgt", F_PC, 32'h4180);
    exc_req = 0; stall = 0; eret_req = 1; epc = 32'h3010;
    cyc("eret");
    chk("eret_tgt", F_PC, 32'h3010);
    eret_req = 0;

    // JL blocked by stall, then taken.
    npc_op = 4'd2; d_pc = 32'h3000; imm26 = 26'h0000c05; stall = 1; fetch_ready = 1;
    cyc("jl_stall");
    stall = 0;
    cyc("jl");
    chk("jl_tgt", F_PC, 32'h3014);

    // Address-error cases.
    npc_op = 4'd3; rs = 32'h3002;
    cyc("adel_mis");
`ifdef PC_ADEL_CHECK_EN
    chk("adel_mis_flag", {31'd0, pc_adel}, 32'd1);
`else
    chk("adel_mis_flag", {31'd0, pc_adel}, 32'd0);
`endif
    rs = 32'h7000;
    cyc("adel_rng");
`ifdef PC_ADEL_CHECK_EN
    chk("adel_rng_flag", {31'd0, pc_adel}, 32'd1);
`else
    chk("adel_rng_flag", {31'd0, pc_adel}, 32'd0);
`endif

    // Reset asserted in HOLD drops the pending target at once.
    rs = 32'h3800; fetch_ready = 0;
    cyc("pre_rst");
    reset = 1'b0;
    #1;
    model_reset();
    check_all("rst_hold");
    @(posedge clk);
    #1;
    reset = 1'b1;
    idle_inputs();

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      stall       = ($urandom_range(0, 99) < 15);
      fetch_ready = ($urandom_range(0, 99) < 65);
      exc_req     = ($urandom_range(0, 99) < 3);
      eret_req    = ($urandom_range(0, 99) < 4);
      epc         = 32'h3000 + ($urandom_range(0, 4095) << 2);
      npc_op      = 4'($urandom_range(0, 5));
      branch      = $urandom_range(0, 1);
      d_pc        = 32'h3000 + ($urandom_range(0, 4095) << 2);
      imm16       = 16'($urandom);
      imm26       = 26'($urandom);
      rs          = ($urandom_range(0, 9) == 0) ? $urandom : 32'h3000 + ($urandom_range(0, 4095) << 2);
      cyc("rand");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
